// File: rtl/bus_master_if_pkg.sv
// Shared constants for the request/grant bus master interface: bus widths,
// polarity encodings and the master-side FSM state codes.
package bus_master_if_pkg;

  localparam int BUS_ADDR_W     = 30;
  localparam int WORD_DATA_W    = 32;
  localparam int BUS_IF_STATE_W = 2;

  localparam logic READ         = 1'b1;
  localparam logic WRITE        = 1'b0;
  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;

  typedef enum logic [BUS_IF_STATE_W-1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } bus_if_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Master-side initiator of the shared request/grant bus: latches one requester
// access, arbitrates for the bus, runs the address/ready handshake, reports completion.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_as_,
  input  logic [BUS_ADDR_W-1:0]  req_addr,
  input  logic                   req_rw,
  input  logic [WORD_DATA_W-1:0] req_wr_data,
  output logic [WORD_DATA_W-1:0] req_rd_data,
  output logic                   busy,
  output logic                   err,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [BUS_ADDR_W-1:0]  bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output bus_if_state_e          dbg_state
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_MAX   = '1;

  bus_if_state_e          state;
  logic [BUS_ADDR_W-1:0]  addr_q;
  logic                   rw_q;
  logic [WORD_DATA_W-1:0] wr_data_q;
  logic [WORD_DATA_W-1:0] rd_data_q;
  logic [TO_W-1:0]        to_cnt;
  logic                   complete;
  logic                   abort;

  assign dbg_state = state;

  // The counter is zero in ACCESS, so a timeout can only be reached in WAIT.
  assign complete = ((state == ACCESS) || (state == WAIT)) && (bus_rdy_ == ENABLE_);
  assign abort    = (state == WAIT) && (bus_rdy_ == DISABLE_) && (to_cnt == TO_LIMIT);

  assign busy = !(complete || abort) && ((state != IDLE) || (req_as_ == ENABLE_));
  assign err  = abort;

  always_comb begin
    req_rd_data = rd_data_q;
    if (complete && (bus_rw == READ)) begin
      req_rd_data = bus_rd_data;
    end else if (abort) begin
      req_rd_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ENABLE) begin
      state       <= IDLE;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_addr    <= '0;
      bus_rw      <= READ;
      bus_wr_data <= '0;
      addr_q      <= '0;
      rw_q        <= READ;
      wr_data_q   <= '0;
      rd_data_q   <= '0;
      to_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_as_ == ENABLE_) begin
            addr_q    <= req_addr;
            rw_q      <= req_rw;
            wr_data_q <= req_wr_data;
            bus_req_  <= ENABLE_;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_grnt_ == ENABLE_) begin
            bus_as_     <= ENABLE_;
            bus_addr    <= addr_q;
            bus_rw      <= rw_q;
            bus_wr_data <= wr_data_q;
            to_cnt      <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS, WAIT: begin
          bus_as_ <= DISABLE_;
          if (complete) begin
            if (bus_rw == READ) rd_data_q <= bus_rd_data;
            bus_req_ <= DISABLE_;
            state    <= IDLE;
          end else if (abort) begin
            rd_data_q <= '0;
            bus_req_  <= DISABLE_;
            state     <= IDLE;
          end else begin
            if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: per-cycle vector table for read/write,
// then hand sequences for delayed grant, timeout, reset mid-access and two-master rotation.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Master 0 (bench-driven grant unless the two-master arbiter is active)
  logic        as0_n = 1'b1, rw0 = 1'b1, g0_n = 1'b1, rdy0_n = 1'b1;
  logic [29:0] addr0 = '0;
  logic [31:0] wd0 = '0, rdd0 = '0;
  logic [31:0] rd0;
  logic        busy0, err0, breq0_n, bas0_n, brw0, grnt0_n;
  logic [29:0] baddr0;
  logic [31:0] bwd0;
  bus_if_state_e st0;

  // Master 1 (only active during the rotation test)
  logic        as1_n = 1'b1, rdy1_n = 1'b1;
  logic [31:0] rdd1 = '0;
  logic [31:0] rd1;
  logic        busy1, err1, breq1_n, bas1_n, brw1, grnt1_n;
  logic [29:0] baddr1;
  logic [31:0] bwd1;
  bus_if_state_e st1;

  logic       arb_mode = 1'b0;
  logic [1:0] gnt;
  logic       last_gnt;

  assign grnt0_n = arb_mode ? ~gnt[0] : g0_n;
  assign grnt1_n = arb_mode ? ~gnt[1] : 1'b1;

  bus_master_if #(.TIMEOUT(4), .TO_W(8)) dut0 (
    .clk(clk), .reset(reset), .req_as_(as0_n), .req_addr(addr0), .req_rw(rw0),
    .req_wr_data(wd0), .req_rd_data(rd0), .busy(busy0), .err(err0),
    .bus_req_(breq0_n), .bus_grnt_(grnt0_n), .bus_addr(baddr0), .bus_as_(bas0_n),
    .bus_rw(brw0), .bus_wr_data(bwd0), .bus_rd_data(rdd0), .bus_rdy_(rdy0_n),
    .dbg_state(st0)
  );

  bus_master_if #(.TIMEOUT(4), .TO_W(8)) dut1 (
    .clk(clk), .reset(reset), .req_as_(as1_n), .req_addr(30'h0000_0200), .req_rw(READ),
    .req_wr_data(32'h0), .req_rd_data(rd1), .busy(busy1), .err(err1),
    .bus_req_(breq1_n), .bus_grnt_(grnt1_n), .bus_addr(baddr1), .bus_as_(bas1_n),
    .bus_rw(brw1), .bus_wr_data(bwd1), .bus_rd_data(rdd1), .bus_rdy_(rdy1_n),
    .dbg_state(st1)
  );

  // Two-master round-robin arbiter: grant held until the owner drops its request.
  always @(posedge clk) begin
    if (!arb_mode) begin
      gnt      <= 2'b00;
      last_gnt <= 1'b1;
    end else if (gnt == 2'b00) begin
      if (!breq0_n && !breq1_n) begin
        gnt      <= last_gnt ? 2'b01 : 2'b10;
        last_gnt <= ~last_gnt;
      end else if (!breq0_n) begin
        gnt      <= 2'b01;
        last_gnt <= 1'b0;
      end else if (!breq1_n) begin
        gnt      <= 2'b10;
        last_gnt <= 1'b1;
      end
    end else if ((gnt[0] && breq0_n) || (gnt[1] && breq1_n)) begin
      gnt <= 2'b00;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        as_n;
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wd;
    logic        grnt_n;
    logic        rdy_n;
    logic [31:0] rdd;
    logic        e_busy;
    logic        e_req_n;
    logic        e_as_n;
    logic        e_err;
    logic        e_rw;
    logic [29:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Read with immediate grant/ready, then write with three wait states and a dropped grant.
    vecs[0]  = '{1'b0, 30'h0000_0100, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 30'h0,          32'h0,        32'h0};
    vecs[1]  = '{1'b0, 30'h0000_0100, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 30'h0,          32'h0,        32'h0};
    vecs[2]  = '{1'b0, 30'h0000_0100, 1'b1, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0000_0100, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b1, 30'h0,         1'b1, 32'h0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 30'h0000_0100, 32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b0, 30'h2000_0004, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 30'h0000_0100, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b0, 30'h2000_0004, 1'b0, 32'h12345678, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 30'h0000_0100, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b0, 30'h2000_0004, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h2000_0004, 32'h12345678, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 30'h2000_0004, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 30'h2000_0004, 32'h12345678, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 30'h2000_0004, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 30'h2000_0004, 32'h12345678, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 30'h2000_0004, 1'b0, 32'h12345678, 1'b1, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h2000_0004, 32'h12345678, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 30'h0,         1'b1, 32'h0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h2000_0004, 32'h12345678, 32'hDEADBEEF};

    // Reset
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_bus_req", 32'(breq0_n), 32'h1);
    check("rst_bus_as", 32'(bas0_n), 32'h1);
    check("rst_bus_addr", 32'(baddr0), 32'h0);
    check("rst_bus_rw", 32'(brw0), 32'(READ));
    check("rst_bus_wr_data", bwd0, 32'h0);
    check("rst_rd_data", rd0, 32'h0);
    check("rst_err", 32'(err0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      as0_n = vecs[i].as_n; addr0 = vecs[i].addr; rw0 = vecs[i].rw; wd0 = vecs[i].wd;
      g0_n = vecs[i].grnt_n; rdy0_n = vecs[i].rdy_n; rdd0 = vecs[i].rdd;
      #1;
      check($sformatf("v%0d_busy", i), 32'(busy0), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_bus_req", i), 32'(breq0_n), 32'(vecs[i].e_req_n));
      check($sformatf("v%0d_bus_as", i), 32'(bas0_n), 32'(vecs[i].e_as_n));
      check($sformatf("v%0d_err", i), 32'(err0), 32'(vecs[i].e_err));
      check($sformatf("v%0d_bus_rw", i), 32'(brw0), 32'(vecs[i].e_rw));
      check($sformatf("v%0d_bus_addr", i), 32'(baddr0), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_bus_wr_data", i), bwd0, vecs[i].e_wd);
      check($sformatf("v%0d_rd_data", i), rd0, vecs[i].e_rd);
    end

    // Delayed grant; requester inputs wander while busy and must be ignored.
    @(negedge clk);
    as0_n = 1'b0; addr0 = 30'h0000_0333; rw0 = READ; g0_n = 1'b1; rdy0_n = 1'b1;
    #1;
    check("dg_busy_c0", 32'(busy0), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      addr0 = 30'h3FFF_0000 + 30'(i);
      rw0   = WRITE;
      #1;
      check($sformatf("dg_wait%0d_req", i), 32'(breq0_n), 32'h0);
      check($sformatf("dg_wait%0d_as", i), 32'(bas0_n), 32'h1);
      check($sformatf("dg_wait%0d_busy", i), 32'(busy0), 32'h1);
    end
    @(negedge clk);
    g0_n = 1'b0;
    #1;
    check("dg_grant_as", 32'(bas0_n), 32'h1);
    @(negedge clk);
    g0_n = 1'b1; rdy0_n = 1'b0; rdd0 = 32'hCAFEF00D;
    #1;
    check("dg_access_as", 32'(bas0_n), 32'h0);
    check("dg_latched_addr", 32'(baddr0), 32'h0000_0333);
    check("dg_latched_rw", 32'(brw0), 32'(READ));
    check("dg_busy_done", 32'(busy0), 32'h0);
    check("dg_rd_data", rd0, 32'hCAFEF00D);
    @(negedge clk);
    as0_n = 1'b1; rdy0_n = 1'b1; rdd0 = 32'h0;
    #1;
    check("dg_release", 32'(breq0_n), 32'h1);
    check("dg_rd_held", rd0, 32'hCAFEF00D);

    // Timeout with ready never asserted: abort four cycles after ACCESS.
    @(negedge clk);
    as0_n = 1'b0; addr0 = 30'h0000_0044; rw0 = READ; g0_n = 1'b1;
    @(negedge clk);
    g0_n = 1'b0;
    @(negedge clk);
    g0_n = 1'b1;
    #1;
    check("to_access_as", 32'(bas0_n), 32'h0);
    begin
      logic found;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        #1;
        if (err0) begin
          check("to_err_cycle", 32'(k), 32'd4);
          check("to_rd_zero", rd0, 32'h0);
          check("to_busy", 32'(busy0), 32'h0);
          found = 1'b1;
          break;
        end
      end
      check("to_err_seen", 32'(found), 32'h1);
    end
    @(negedge clk);
    as0_n = 1'b1;
    #1;
    check("to_release", 32'(breq0_n), 32'h1);
    check("to_err_one_cycle", 32'(err0), 32'h0);
    check("to_rd_cleared", rd0, 32'h0);

    // Reset during WAIT, then a clean access.
    @(negedge clk);
    rdd0 = 32'h1111_2222; as0_n = 1'b0; addr0 = 30'h0000_0055; rw0 = READ; g0_n = 1'b1;
    @(negedge clk);
    g0_n = 1'b0;
    @(negedge clk);
    g0_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; as0_n = 1'b1;
    #1;
    check("rw_pre_err", 32'(err0), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_req_released", 32'(breq0_n), 32'h1);
    check("rw_as_released", 32'(bas0_n), 32'h1);
    check("rw_busy_idle", 32'(busy0), 32'h0);
    check("rw_no_err", 32'(err0), 32'h0);
    check("rw_state_idle", 32'(st0), 32'(IDLE));
    @(negedge clk);
    as0_n = 1'b0; addr0 = 30'h0000_0066; rw0 = READ;
    @(negedge clk);
    g0_n = 1'b0;
    @(negedge clk);
    g0_n = 1'b1; rdy0_n = 1'b0; rdd0 = 32'h0BAD_F00D;
    #1;
    check("rw_new_busy", 32'(busy0), 32'h0);
    check("rw_new_addr", 32'(baddr0), 32'h0000_0066);
    check("rw_new_rd", rd0, 32'h0BAD_F00D);
    @(negedge clk);
    as0_n = 1'b1; rdy0_n = 1'b1;
    #1;
    check("rw_new_release", 32'(breq0_n), 32'h1);

    // Two masters requesting continuously on the round-robin arbiter.
    @(negedge clk);
    arb_mode = 1'b1;
    as0_n = 1'b0; addr0 = 30'h0000_0100; rw0 = READ; rdy0_n = 1'b0; rdd0 = 32'hA0A0_A0A0;
    as1_n = 1'b0; rdy1_n = 1'b0; rdd1 = 32'hB1B1_B1B1;
    begin
      int  acc0, acc1;
      logic rel0, rel1;
      acc0 = 0; acc1 = 0; rel0 = 1'b0; rel1 = 1'b0;
      for (int c = 0; c < 60; c++) begin
        #1;
        if (breq0_n) rel0 = 1'b1;
        if (breq1_n) rel1 = 1'b1;
        check($sformatf("b2b_c%0d_one_owner", c), 32'(!bas0_n && !bas1_n), 32'h0);
        if (!bas0_n) begin
          if (acc0 > 0) check($sformatf("b2b_m0_release%0d", acc0), 32'(rel0), 32'h1);
          if (exp_q.size() > 0) check($sformatf("b2b_order_m0_%0d", acc0), 32'h0, exp_q.pop_front());
          exp_q.push_back(32'h1);
          check($sformatf("b2b_m0_rd%0d", acc0), rd0, 32'hA0A0_A0A0);
          rel0 = 1'b0;
          acc0++;
        end
        if (!bas1_n) begin
          if (acc1 > 0) check($sformatf("b2b_m1_release%0d", acc1), 32'(rel1), 32'h1);
          if (exp_q.size() > 0) check($sformatf("b2b_order_m1_%0d", acc1), 32'h1, exp_q.pop_front());
          exp_q.push_back(32'h0);
          check($sformatf("b2b_m1_rd%0d", acc1), rd1, 32'hB1B1_B1B1);
          rel1 = 1'b0;
          acc1++;
        end
        @(negedge clk);
      end
      check("b2b_m0_progress", 32'(acc0 >= 3), 32'h1);
      check("b2b_m1_progress", 32'(acc1 >= 3), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
